// File: rtl/hazard_forward_ctrl_if.sv
// Hazard/forwarding controller bus: ID-stage decode info, EX/MEM pipeline
// events in, pipeline enables, forward selects and event counters out.
interface hazard_forward_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      ex_branch_taken;
  logic                      mem_stall;
  logic                      pc_write;
  logic                      if_id_write;
  logic                      if_id_flush;
  logic                      id_ex_bubble;
  logic [1:0]                forwardA;
  logic [1:0]                forwardB;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;

  // Pipeline side: supplies decode info, consumes control
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           forwardA, forwardB, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           forwardA, forwardB, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline. Tracks the
// destination registers of the EX and MEM instructions, produces registered
// forward selects for the EX operand muxes, and decides load-use stalls,
// branch flushes and memory freezes. Saturating stall/flush event counters.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_LOAD_USE,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // Shadow of the instruction in EX
  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;

  // Shadow of the instruction in MEM
  logic                      mem_valid;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_reg_write;

  logic [1:0]                fwd_a_q;
  logic [1:0]                fwd_b_q;
  logic [1:0]                fwd_a_d;
  logic [1:0]                fwd_b_d;
  logic [CNT_WIDTH-1:0]      stall_cnt_q;
  logic [CNT_WIDTH-1:0]      flush_cnt_q;

  logic                      load_use;
  logic                      bubble;
  mode_e                     mode;

  // Forward select for one source; the younger EX producer wins over MEM
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      use_rs,
    input logic                      e_valid,
    input logic                      e_reg_write,
    input logic [REG_ADDR_WIDTH-1:0] e_rd,
    input logic                      m_valid,
    input logic                      m_reg_write,
    input logic [REG_ADDR_WIDTH-1:0] m_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_rs && (rs != '0)) begin
      if (e_valid && e_reg_write && (e_rd == rs))
        sel = SEL_ALU;
      else if (m_valid && m_reg_write && (m_rd == rs))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  // Next forward selects for the ID instruction against current EX/MEM
  always_comb begin
    fwd_a_d = fwd_sel(bus.id_rs1, bus.id_uses_rs1, ex_valid, ex_reg_write,
                      ex_rd, mem_valid, mem_reg_write, mem_rd);
    fwd_b_d = fwd_sel(bus.id_rs2, bus.id_uses_rs2, ex_valid, ex_reg_write,
                      ex_rd, mem_valid, mem_reg_write, mem_rd);
  end

  // Load in EX whose result the ID instruction needs
  always_comb begin
    load_use = bus.id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
               ((bus.id_uses_rs1 && (bus.id_rs1 == ex_rd)) ||
                (bus.id_uses_rs2 && (bus.id_rs2 == ex_rd)));
  end

  // Mode priority: freeze > flush > load-use > normal
  always_comb begin
    mode = MODE_NORMAL;
    if (bus.mem_stall)
      mode = MODE_FREEZE;
    else if (bus.ex_branch_taken)
      mode = MODE_FLUSH;
    else if (load_use)
      mode = MODE_LOAD_USE;
  end

  // Pipeline enables decoded from the mode
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    unique case (mode)
      MODE_FREEZE: begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
      end
      MODE_FLUSH: begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end
      MODE_LOAD_USE: begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign bubble = (mode == MODE_FLUSH) || (mode == MODE_LOAD_USE);

  // Advance shadow state and forward selects on every non-freeze edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      fwd_a_q       <= SEL_RF;
      fwd_b_q       <= SEL_RF;
    end else if (mode != MODE_FREEZE) begin
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (bubble) begin
        ex_valid <= 1'b0;
        fwd_a_q  <= SEL_RF;
        fwd_b_q  <= SEL_RF;
      end else begin
        ex_valid     <= bus.id_valid;
        ex_rd        <= bus.id_rd;
        ex_reg_write <= bus.id_reg_write;
        ex_mem_read  <= bus.id_mem_read;
        fwd_a_q      <= fwd_a_d;
        fwd_b_q      <= fwd_b_d;
      end
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((mode == MODE_LOAD_USE) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if ((mode == MODE_FLUSH) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.forwardA  = fwd_a_q;
  assign bus.forwardB  = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use, flush,
// freeze, reset and counter saturation (second instance with 4-bit counters).
module tb_hazard_forward_ctrl;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  hazard_forward_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
  hazard_forward_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  bus4 ();

  hazard_forward_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  hazard_forward_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // Narrow-counter instance sees the same stimulus
  assign bus4.id_valid        = bus.id_valid;
  assign bus4.id_rs1          = bus.id_rs1;
  assign bus4.id_rs2          = bus.id_rs2;
  assign bus4.id_uses_rs1     = bus.id_uses_rs1;
  assign bus4.id_uses_rs2     = bus.id_uses_rs2;
  assign bus4.id_rd           = bus.id_rd;
  assign bus4.id_reg_write    = bus.id_reg_write;
  assign bus4.id_mem_read     = bus.id_mem_read;
  assign bus4.ex_branch_taken = bus.ex_branch_taken;
  assign bus4.mem_stall       = bus.mem_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_uses_rs1  = u1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic pc, input logic ifw,
                            input logic fl, input logic bb);
    check({tag, ".pc_write"},     32'(bus.pc_write),     32'(pc));
    check({tag, ".if_id_write"},  32'(bus.if_id_write),  32'(ifw));
    check({tag, ".if_id_flush"},  32'(bus.if_id_flush),  32'(fl));
    check({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(bb));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_stall       = 1'b0;
    nop();
    tick();
    tick();

    // Reset values
    check("rst.forwardA", 32'(bus.forwardA), 32'd0);
    check("rst.forwardB", 32'(bus.forwardB), 32'd0);
    check("rst.stall_cnt", bus.stall_cnt, 32'd0);
    check("rst.flush_cnt", bus.flush_cnt, 32'd0);
    check_ctrl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // add x1; add x2,x1 -> EX forward
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    check("ex_fwd.forwardA", 32'(bus.forwardA), 32'd2);
    check("ex_fwd.forwardB", 32'(bus.forwardB), 32'd0);
    nop();
    tick();

    // add x3; nop; sub x4,x3,x3 -> MEM forward on both
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    check("mem_fwd.forwardA", 32'(bus.forwardA), 32'd1);
    check("mem_fwd.forwardB", 32'(bus.forwardB), 32'd1);

    // EX and MEM both write x5 -> EX wins; rs2 = x0 -> register file
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    check("dual.forwardA", 32'(bus.forwardA), 32'd2);
    check("dual.forwardB", 32'(bus.forwardB), 32'd0);

    // lw x6; add x7,x6 -> one bubble then MEM forward
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    check_ctrl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lu.stall_cnt", bus.stall_cnt, 32'd1);
    check("lu.bubble_forwardA", 32'(bus.forwardA), 32'd0);
    check_ctrl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("lu.forwardA", 32'(bus.forwardA), 32'd1);
    check("lu.stall_cnt_once", bus.stall_cnt, 32'd1);

    // lw x0; add x1,x0 -> no stall, no forward
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    check_ctrl("x0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("x0.forwardA", 32'(bus.forwardA), 32'd0);

    // add x8; rs2 = x8 unused -> 00; then used from MEM -> 01
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("unused.forwardB", 32'(bus.forwardB), 32'd0);
    issue(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    check("used.forwardB", 32'(bus.forwardB), 32'd1);

    // Flush with a simultaneous load-use
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b1;
    #1;
    check_ctrl("flush", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    bus.ex_branch_taken = 1'b0;
    check("flush.stall_cnt", bus.stall_cnt, 32'd1);
    check("flush.flush_cnt", bus.flush_cnt, 32'd1);
    check("flush.forwardA", 32'(bus.forwardA), 32'd0);

    // add x11; add x12,x11; freeze 3 cycles with add x13,x12,x11 waiting
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    check("pre_frz.forwardA", 32'(bus.forwardA), 32'd2);
    issue(1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 1'b0);
    bus.mem_stall       = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    check_ctrl("frz", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz.forwardA", 32'(bus.forwardA), 32'd2);
      check("frz.forwardB", 32'(bus.forwardB), 32'd0);
    end
    check("frz.flush_cnt", bus.flush_cnt, 32'd1);
    bus.mem_stall       = 1'b0;
    bus.ex_branch_taken = 1'b0;
    tick();
    check("resume.forwardA", 32'(bus.forwardA), 32'd2);
    check("resume.forwardB", 32'(bus.forwardB), 32'd1);

    // Mid-stream reset discards the tracked producer
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    check("pre_rst.forwardA", 32'(bus.forwardA), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mrst.forwardA", 32'(bus.forwardA), 32'd0);
    check("mrst.stall_cnt", bus.stall_cnt, 32'd0);
    check("mrst.flush_cnt", bus.flush_cnt, 32'd0);
    check_ctrl("mrst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    check("post_rst.forwardA", 32'(bus.forwardA), 32'd0);

    // 20 flushes: 4-bit counter saturates at 15
    bus.ex_branch_taken = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("sat15.flush_cnt4", 32'(bus4.flush_cnt), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    bus.ex_branch_taken = 1'b0;
    check("sat.flush_cnt4", 32'(bus4.flush_cnt), 32'd15);
    check("sat.flush_cnt32", bus.flush_cnt, 32'd20);
    check("sat.stall_cnt4", 32'(bus4.stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
